loop_recorder: RTL
==================

Name: loop_recorder

Overview:
- Parametrised successor to the synth's single-track key recorder.
- Captures a NUM_KEYS-wide key-state vector into an on-chip buffer as run-length entries {keys, duration}, measured in ticks of an external time-base strobe.
- Plays the buffer back on play_keys, which feeds the tone generators and the GUI.
- Reports its mode so the GUI can show IDLE/REC/PLAY.

Parameters:
- NUM_KEYS, 4, width of the key vector.
- DEPTH, 16, maximum number of stored entries.
- DUR_W, 8, duration field width; maximum run is 2^DUR_W-1 ticks.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-low reset.
- go  in  1  single-cycle start/stop pulse, active high; the top level edge-detects the key.
- rec_sel  in  1  sampled with go in IDLE: 1 = record, 0 = play.
- tick  in  1  single-cycle time-base enable.
- keys  in  NUM_KEYS  live key state.
- mode  out  2  0 = IDLE, 1 = REC, 2 = PLAY.
- play_keys  out  NUM_KEYS  replayed key state; 0 when not playing.
- rec_count  out  $clog2(DEPTH+1)  number of valid stored entries.
- full  out  1  buffer filled during the last recording.
- done  out  1  one-cycle pulse on every return to IDLE.

Behaviour:
- Reset is asynchronous, active-low, and allowed at any time, including mid-record or mid-play. It forces:
  - state IDLE, mode 0, play_keys 0
  - rec_count 0, full 0, done 0
  - pointers and duration counters 0
- Buffer contents are not cleared by reset; rec_count 0 makes them invalid.
- States: IDLE, REC, LOAD, HOLD. mode = 2 in both LOAD and HOLD.
- If go and tick arrive in the same cycle, go wins and the tick is ignored.
- IDLE, go with rec_sel=1 -> REC:
  - wr_ptr=0, rec_count=0, full=0, dur=0.
- REC, on each tick:
  - dur==0: cur_keys<=keys, dur<=1.
  - keys==cur_keys and dur<max: dur<=dur+1.
  - otherwise: write {cur_keys,dur} at wr_ptr, wr_ptr++, rec_count++, then cur_keys<=keys, dur<=1.
  - Runs longer than max therefore split into several entries with equal keys.
- REC, when a write makes rec_count==DEPTH: full<=1, pending sample discarded, -> IDLE with done.
- REC, on go: if dur>0, flush the pending entry (space is guaranteed because the buffer is not full); -> IDLE with done.
- IDLE, go with rec_sel=0:
  - rec_count==0: stay IDLE, pulse done.
  - otherwise: rd_ptr=0, -> LOAD.
- LOAD: present rd_ptr to the RAM, which has a 1-cycle read latency. On the next edge capture the entry: play_keys<=entry.keys, remain<=entry.dur, -> HOLD.
- HOLD, on each tick: remain--. When remain reaches 0: rd_ptr++.
  - rd_ptr==rec_count: -> IDLE, play_keys<=0, done.
  - otherwise: -> LOAD. play_keys holds its old value through LOAD, so there is no zero glitch between entries.
- LOAD or HOLD, on go: -> IDLE next edge, play_keys<=0, done.
- Any go in LOAD or HOLD means stop; rec_sel is ignored.
- All outputs are registered.
- Entry width is NUM_KEYS+DUR_W. Duration never wraps: it saturates and splits.

Optional Feature:
- Macro: LOOP_RECORDER_LOOP_EN.
- Defined: at end of buffer in HOLD, rd_ptr<=0 and -> LOAD instead of IDLE. Playback repeats until go. done pulses once per wrap and once on stop.
- Undefined: single-pass playback as above.

Decomposition:
- Package synth_rec_pkg holds:
  - mode encoding constants: MODE_IDLE=0, MODE_REC=1, MODE_PLAY=2.
  - the state enum.
  - the entry struct/width helper function.
- Sub-module rec_ram: simple dual-port synchronous RAM, DEPTH x (NUM_KEYS+DUR_W), 1-cycle read latency, no reset. It infers to M10K.

Test Plan (NUM_KEYS=4, DEPTH=8, DUR_W=4):
1. Record 0001 for 3 ticks, then 0010 for 2 ticks, then go.
   -> rec_count=2, entries {0001,3},{0010,2}, done pulse, mode 0.
2. Play after scenario 1.
   -> play_keys 0001 for 3 ticks, then 0010 for 2 ticks; then done, mode 0, play_keys 0.
3. Record 0100 held for 20 ticks, then go.
   -> entries {0100,15},{0100,5}, rec_count=2.
4. Record keys alternating 0001/0010 every tick for 12 ticks.
   -> full=1 and mode 0 on the 8th write, rec_count=8, later ticks ignored.
5. go at tick 2 of playback.
   -> next cycle mode 0, play_keys 0, done.
   Also: play with rec_count=0 -> mode stays 0, done pulses.
6. Assert reset mid-REC and mid-HOLD.
   -> all outputs at reset values immediately.
   With LOOP_RECORDER_LOOP_EN defined, scenario 2 repeats 0001x3, 0010x2 continuously until go.

Source files
------------

// File: rtl/loop_recorder_pkg.sv
//============================================================================
// synth_rec_pkg : mode codes, state encoding and entry sizing for loop_recorder
// Revision: 1.0
//============================================================================
`default_nettype none

package synth_rec_pkg;

    localparam logic [1:0] MODE_IDLE = 2'd0;
    localparam logic [1:0] MODE_REC  = 2'd1;
    localparam logic [1:0] MODE_PLAY = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REC  = 2'd1,
        ST_LOAD = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Stored entry is {keys, duration}, keys in the upper bits.
    function automatic int entry_width(input int num_keys, input int dur_w);
        return num_keys + dur_w;
    endfunction

    function automatic logic [1:0] state_mode(input state_t st);
        logic [1:0] m;
        m = MODE_IDLE;
        case (st)
            ST_REC:           m = MODE_REC;
            ST_LOAD, ST_HOLD: m = MODE_PLAY;
            default:          m = MODE_IDLE;
        endcase
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/loop_recorder_rec_ram.sv
//============================================================================
// rec_ram : simple dual-port synchronous RAM, 1-cycle read latency, no reset
// Revision: 1.0
//============================================================================
`default_nettype none

module rec_ram #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 12,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata_q <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata_q;

endmodule

`default_nettype wire

// File: rtl/loop_recorder.sv
//============================================================================
// loop_recorder : run-length key recorder / player on an external tick base.
// Optional LOOP_RECORDER_LOOP_EN: playback wraps to the first entry until go.
// Revision: 1.0
//============================================================================
`default_nettype none

module loop_recorder
    import synth_rec_pkg::*;
#(
    parameter  int NUM_KEYS = 4,
    parameter  int DEPTH    = 16,
    parameter  int DUR_W    = 8,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                go,
    input  logic                rec_sel,
    input  logic                tick,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [1:0]          mode,
    output logic [NUM_KEYS-1:0] play_keys,
    output logic [CNT_W-1:0]    rec_count,
    output logic                full,
    output logic                done
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENTRY_W = entry_width(NUM_KEYS, DUR_W);

    localparam logic [DUR_W-1:0] C_DUR_MAX  = {DUR_W{1'b1}};
    localparam logic [DUR_W-1:0] C_DUR_ONE  = DUR_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1);

    state_t                r_state_q,     w_state_d;
    logic [1:0]            r_mode_q,      w_mode_d;
    logic [PTR_W-1:0]      r_wr_ptr_q,    w_wr_ptr_d;
    logic [PTR_W-1:0]      r_rd_ptr_q,    w_rd_ptr_d;
    logic [CNT_W-1:0]      r_rec_count_q, w_rec_count_d;
    logic                  r_full_q,      w_full_d;
    logic                  r_done_q,      w_done_d;
    logic [NUM_KEYS-1:0]   r_play_keys_q, w_play_keys_d;
    logic [NUM_KEYS-1:0]   r_cur_keys_q,  w_cur_keys_d;
    logic [DUR_W-1:0]      r_dur_q,       w_dur_d;
    logic [DUR_W-1:0]      r_remain_q,    w_remain_d;

    logic                  w_we;
    logic [ENTRY_W-1:0]    w_wdata;
    logic [ENTRY_W-1:0]    w_rdata;
    logic [NUM_KEYS-1:0]   w_rd_keys;
    logic [DUR_W-1:0]      w_rd_dur;
    logic [CNT_W-1:0]      w_rd_next;

    assign w_wdata   = {r_cur_keys_q, r_dur_q};
    assign w_rd_keys = w_rdata[ENTRY_W-1 -: NUM_KEYS];
    assign w_rd_dur  = w_rdata[DUR_W-1:0];
    assign w_rd_next = CNT_W'(r_rd_ptr_q) + C_CNT_ONE;

    // Read address follows the next pointer so the entry is ready during LOAD.
    rec_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk     (clock),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr_q),
        .i_wdata (w_wdata),
        .i_raddr (w_rd_ptr_d),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_wr_ptr_d    = r_wr_ptr_q;
        w_rd_ptr_d    = r_rd_ptr_q;
        w_rec_count_d = r_rec_count_q;
        w_full_d      = r_full_q;
        w_done_d      = 1'b0;
        w_play_keys_d = r_play_keys_q;
        w_cur_keys_d  = r_cur_keys_q;
        w_dur_d       = r_dur_q;
        w_remain_d    = r_remain_q;
        w_we          = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (go) begin
                    if (rec_sel) begin
                        w_state_d     = ST_REC;
                        w_wr_ptr_d    = '0;
                        w_rec_count_d = '0;
                        w_full_d      = 1'b0;
                        w_dur_d       = '0;
                    end else if (r_rec_count_q == '0) begin
                        w_done_d = 1'b1;
                    end else begin
                        w_rd_ptr_d = '0;
                        w_state_d  = ST_LOAD;
                    end
                end
            end

            ST_REC: begin
                if (go) begin
                    if (r_dur_q != '0) begin
                        w_we          = 1'b1;
                        w_wr_ptr_d    = r_wr_ptr_q + C_PTR_ONE;
                        w_rec_count_d = r_rec_count_q + C_CNT_ONE;
                    end
                    w_dur_d   = '0;
                    w_state_d = ST_IDLE;
                    w_done_d  = 1'b1;
                end else if (tick) begin
                    if (r_dur_q == '0) begin
                        w_cur_keys_d = keys;
                        w_dur_d      = C_DUR_ONE;
                    end else if (keys == r_cur_keys_q && r_dur_q != C_DUR_MAX) begin
                        w_dur_d = r_dur_q + C_DUR_ONE;
                    end else begin
                        w_we          = 1'b1;
                        w_wr_ptr_d    = r_wr_ptr_q + C_PTR_ONE;
                        w_rec_count_d = r_rec_count_q + C_CNT_ONE;
                        // Last slot used: the sample that forced the write is dropped.
                        if (r_rec_count_q == C_CNT_LAST) begin
                            w_full_d  = 1'b1;
                            w_dur_d   = '0;
                            w_state_d = ST_IDLE;
                            w_done_d  = 1'b1;
                        end else begin
                            w_cur_keys_d = keys;
                            w_dur_d      = C_DUR_ONE;
                        end
                    end
                end
            end

            ST_LOAD: begin
                if (go) begin
                    w_state_d     = ST_IDLE;
                    w_play_keys_d = '0;
                    w_done_d      = 1'b1;
                end else begin
                    w_play_keys_d = w_rd_keys;
                    w_remain_d    = w_rd_dur;
                    w_state_d     = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (go) begin
                    w_state_d     = ST_IDLE;
                    w_play_keys_d = '0;
                    w_done_d      = 1'b1;
                end else if (tick) begin
                    w_remain_d = r_remain_q - C_DUR_ONE;
                    if (r_remain_q == C_DUR_ONE) begin
                        if (w_rd_next == r_rec_count_q) begin
                            w_done_d = 1'b1;
`ifdef LOOP_RECORDER_LOOP_EN
                            w_rd_ptr_d = '0;
                            w_state_d  = ST_LOAD;
`else
                            w_state_d     = ST_IDLE;
                            w_play_keys_d = '0;
`endif
                        end else begin
                            w_rd_ptr_d = w_rd_next[PTR_W-1:0];
                            w_state_d  = ST_LOAD;
                        end
                    end
                end
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        w_mode_d = state_mode(w_state_d);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state_q     <= ST_IDLE;
            r_mode_q      <= MODE_IDLE;
            r_wr_ptr_q    <= '0;
            r_rd_ptr_q    <= '0;
            r_rec_count_q <= '0;
            r_full_q      <= 1'b0;
            r_done_q      <= 1'b0;
            r_play_keys_q <= '0;
            r_cur_keys_q  <= '0;
            r_dur_q       <= '0;
            r_remain_q    <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_mode_q      <= w_mode_d;
            r_wr_ptr_q    <= w_wr_ptr_d;
            r_rd_ptr_q    <= w_rd_ptr_d;
            r_rec_count_q <= w_rec_count_d;
            r_full_q      <= w_full_d;
            r_done_q      <= w_done_d;
            r_play_keys_q <= w_play_keys_d;
            r_cur_keys_q  <= w_cur_keys_d;
            r_dur_q       <= w_dur_d;
            r_remain_q    <= w_remain_d;
        end
    end

    assign mode      = r_mode_q;
    assign play_keys = r_play_keys_q;
    assign rec_count = r_rec_count_q;
    assign full      = r_full_q;
    assign done      = r_done_q;

endmodule

`default_nettype wire
